// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - request/response handshake bundle for the shift sequencer
interface shift_seq_if #(
    parameter int REG_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_opc;
    logic [CNT_WIDTH-1:0] req_cnt;
    logic [REG_WIDTH-1:0] req_data;
    logic                 req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [REG_WIDTH-1:0] rsp_data;
    logic                 rsp_cout;

    modport master (
        output req_valid, req_opc, req_cnt, req_data, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_cout
    );

    modport slave (
        input  req_valid, req_opc, req_cnt, req_data, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_cout
    );
endinterface

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - sequences a 4-bit-count shift datapath to run arbitrary 8-bit shift counts
module shift_seq #(
    parameter int REG_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_seq_if.slave           bus,
    output logic [REG_WIDTH-1:0] sh_in,
    output logic [3:0]           sh_scnt,
    output logic [1:0]           sh_opc,
    output logic                 sh_sftin,
    input  logic [REG_WIDTH-1:0] sh_out,
    input  logic                 sh_sftout
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [1:0]           opc, opc_n;
    logic [REG_WIDTH-1:0] acc, acc_n;
    logic [CNT_WIDTH-1:0] rem, rem_n;
    logic                 carry, carry_n;
    logic [CNT_WIDTH-1:0] rem_m1;
    logic [3:0]           step;

    assign rem_m1 = rem - CNT_WIDTH'(1);
    // Bulk chunks leave exactly one bit for the final step, which yields the true carry.
    assign step   = (rem_m1 >= CNT_WIDTH'(15)) ? 4'd15 : 4'(rem_m1);

    assign bus.rsp_data = acc;
    assign bus.rsp_cout = carry;
    assign sh_in        = acc;
    assign sh_sftin     = carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            opc   <= 2'b00;
            acc   <= '0;
            rem   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_n;
            opc   <= opc_n;
            acc   <= acc_n;
            rem   <= rem_n;
            carry <= carry_n;
        end
    end

    always_comb begin
        state_n       = state;
        opc_n         = opc;
        acc_n         = acc;
        rem_n         = rem;
        carry_n       = carry;
        sh_scnt       = 4'd0;
        sh_opc        = 2'b00;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    opc_n   = bus.req_opc;
                    acc_n   = bus.req_data;
                    rem_n   = bus.req_cnt;
                    carry_n = bus.req_cin;
                    state_n = (bus.req_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                sh_opc = opc;
                acc_n  = sh_out;
                if (opc == 2'b11) begin
                    sh_scnt = 4'd1;
                    carry_n = sh_sftout;
                    rem_n   = rem_m1;
                    if (rem == CNT_WIDTH'(1)) state_n = S_DONE;
                end else if (rem > CNT_WIDTH'(1)) begin
                    sh_scnt = step;
                    rem_n   = rem - CNT_WIDTH'(step);
                end else begin
                    sh_scnt = 4'd1;
                    carry_n = sh_sftout;
                    rem_n   = '0;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - randomized self-checking bench for shift_seq with an attached datapath model
module tb_shift_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sh_in;
    logic [3:0]   sh_scnt;
    logic [1:0]   sh_opc;
    logic         sh_sftin;
    logic [W-1:0] sh_out;
    logic         sh_sftout;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] r_data;
    logic         r_cout;
    int           r_lat;
    int           r_ssum;
    int           scnt_q[$];

    shift_seq_if #(.REG_WIDTH(W), .CNT_WIDTH(8)) bus ();

    shift_seq #(.REG_WIDTH(W), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .sh_in     (sh_in),
        .sh_scnt   (sh_scnt),
        .sh_opc    (sh_opc),
        .sh_sftin  (sh_sftin),
        .sh_out    (sh_out),
        .sh_sftout (sh_sftout)
    );

    always #5 clk = ~clk;

    // Single-cycle datapath: edge bit is in[MSB] for LSL, in[0] otherwise.
    always_comb begin
        sh_out    = sh_in;
        sh_sftout = (sh_opc == 2'b00) ? sh_in[W-1] : sh_in[0];
        case (sh_opc)
            2'b00: sh_out = sh_in << sh_scnt;
            2'b01: sh_out = sh_in >> sh_scnt;
            2'b10: sh_out = W'($signed(sh_in) >>> sh_scnt);
            2'b11: if (sh_scnt != 4'd0) sh_out = {sh_sftin, sh_in[W-1:1]};
            default: sh_out = sh_in;
        endcase
    end

    function automatic void ref_shift(input logic [1:0] opc, input int cnt, input logic [W-1:0] d,
                                      input logic c, output logic [W-1:0] r, output logic co);
        logic [W:0]       v;
        logic [2*W+1:0]   dv;
        int               k;
        r  = d;
        co = c;
        if (cnt != 0) begin
            case (opc)
                2'b00: begin
                    r  = (cnt >= W) ? '0 : d << cnt;
                    co = (cnt <= W) ? d[W-cnt] : 1'b0;
                end
                2'b01: begin
                    r  = (cnt >= W) ? '0 : d >> cnt;
                    co = (cnt <= W) ? d[cnt-1] : 1'b0;
                end
                2'b10: begin
                    r  = (cnt >= W) ? {W{d[W-1]}} : W'($signed(d) >>> cnt);
                    co = (cnt <= W) ? d[cnt-1] : d[W-1];
                end
                default: begin
                    v  = {c, d};
                    dv = {v, v};
                    k  = cnt % (W + 1);
                    v  = dv[k +: W+1];
                    r  = v[W-1:0];
                    co = v[W];
                end
            endcase
        end
    endfunction

    function automatic int ref_steps(input logic [1:0] opc, input int cnt);
        if (cnt == 0) return 0;
        if (opc == 2'b11) return cnt;
        return 1 + (cnt - 1 + 14) / 15;
    endfunction

    // Presents one request at a negedge and returns at the negedge where rsp_valid is first seen.
    task automatic drive_req(input logic [1:0] opc, input int cnt, input logic [W-1:0] d, input logic c);
        scnt_q.delete();
        bus.req_valid = 1'b1;
        bus.req_opc   = opc;
        bus.req_cnt   = 8'(cnt);
        bus.req_data  = d;
        bus.req_cin   = c;
        @(negedge clk);
        bus.req_valid = 1'b0;
        r_lat  = 1;
        r_ssum = 0;
        while (!bus.rsp_valid && r_lat <= 400) begin
            scnt_q.push_back(int'(sh_scnt));
            r_ssum += int'(sh_scnt);
            r_lat++;
            @(negedge clk);
        end
        r_data = bus.rsp_data;
        r_cout = bus.rsp_cout;
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== '0 || bus.rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0000/0", bus.rsp_data, bus.rsp_cout); end
        checks++; if (sh_scnt !== 4'd0 || sh_opc !== 2'b00) begin errors++; $display("FAIL reset_dp_idle got=%0d/%b exp=0/00", sh_scnt, sh_opc); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int exp_lsr[$];
        int exp_asr[$];
        exp_lsr = '{15, 1};
        exp_asr = '{15, 15, 9, 1};

        drive_req(2'b00, 1, 16'h8001, 1'b0);
        checks++; if (r_data !== 16'h0002 || r_cout !== 1'b1) begin errors++; $display("FAIL lsl1 got=%h/%b exp=0002/1", r_data, r_cout); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL lsl1_latency got=%0d exp=2", r_lat); end
        release_rsp();

        drive_req(2'b01, 16, 16'h8000, 1'b0);
        checks++; if (r_data !== 16'h0000 || r_cout !== 1'b1) begin errors++; $display("FAIL lsr16 got=%h/%b exp=0000/1", r_data, r_cout); end
        checks++; if (scnt_q != exp_lsr) begin errors++; $display("FAIL lsr16_steps got=%p exp=%p", scnt_q, exp_lsr); end
        release_rsp();

        drive_req(2'b10, 40, 16'h8000, 1'b0);
        checks++; if (r_data !== 16'hFFFF || r_cout !== 1'b1) begin errors++; $display("FAIL asr40 got=%h/%b exp=ffff/1", r_data, r_cout); end
        checks++; if (scnt_q != exp_asr) begin errors++; $display("FAIL asr40_steps got=%p exp=%p", scnt_q, exp_asr); end
        release_rsp();

        drive_req(2'b11, 2, 16'h0001, 1'b1);
        checks++; if (r_data !== 16'hC000 || r_cout !== 1'b0) begin errors++; $display("FAIL rrx2 got=%h/%b exp=c000/0", r_data, r_cout); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL rrx2_latency got=%0d exp=3", r_lat); end
        release_rsp();

        drive_req(2'b00, 0, 16'h1234, 1'b1);
        checks++; if (r_data !== 16'h1234 || r_cout !== 1'b1) begin errors++; $display("FAIL cnt0 got=%h/%b exp=1234/1", r_data, r_cout); end
        checks++; if (r_lat !== 1 || sh_scnt !== 4'd0) begin errors++; $display("FAIL cnt0_latency_scnt got=%0d/%0d exp=1/0", r_lat, sh_scnt); end
        release_rsp();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        drive_req(2'b01, 5, 16'hA5A5, 1'b0);
        held = r_data;
        checks++; if (held !== 16'h052D) begin errors++; $display("FAIL bp_result got=%h exp=052d", held); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got=%b/%h/%b exp=1/%h/0", i, bus.rsp_valid, bus.rsp_data, bus.req_ready, held);
            end
        end
        release_rsp();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] e_d;
        logic         e_c;
        bus.req_valid = 1'b1;
        bus.req_opc   = 2'b11;
        bus.req_cnt   = 8'd50;
        bus.req_data  = 16'h1357;
        bus.req_cin   = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (sh_scnt !== 4'd1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL midrun_busy got=%0d/%b exp=1/0", sh_scnt, bus.req_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrun_abort got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
        drive_req(2'b00, 3, 16'h7001, 1'b0);
        ref_shift(2'b00, 3, 16'h7001, 1'b0, e_d, e_c);
        checks++; if (r_data !== e_d || r_cout !== e_c) begin errors++; $display("FAIL after_abort got=%h/%b exp=%h/%b", r_data, r_cout, e_d, e_c); end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e_d;
        logic         e_c;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] opc;
            int cnt;
            logic [W-1:0] d;
            opc = 2'($urandom);
            cnt = $urandom_range(0, 20);
            d   = W'($urandom);
            drive_req(opc, cnt, d, 1'b1);
            ref_shift(opc, cnt, d, 1'b1, e_d, e_c);
            checks++; if (r_data !== e_d || r_cout !== e_c) begin errors++; $display("FAIL b2b_%0d got=%h/%b exp=%h/%b", i, r_data, r_cout, e_d, e_c); end
            @(negedge clk);
            checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d got=%b/%b exp=1/0", i, bus.req_ready, bus.rsp_valid); end
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] e_d;
        logic         e_c;
        for (int i = 0; i < 60; i++) begin
            logic [1:0] opc;
            int cnt;
            logic [W-1:0] d;
            logic c;
            opc = 2'($urandom);
            cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 34);
            d   = W'($urandom);
            c   = 1'($urandom);
            drive_req(opc, cnt, d, c);
            ref_shift(opc, cnt, d, c, e_d, e_c);
            checks++; if (r_data !== e_d || r_cout !== e_c) begin errors++; $display("FAIL rand_%0d opc=%0d cnt=%0d d=%h got=%h/%b exp=%h/%b", i, opc, cnt, d, r_data, r_cout, e_d, e_c); end
            checks++; if (r_lat !== ref_steps(opc, cnt) + 1) begin errors++; $display("FAIL rand_lat_%0d got=%0d exp=%0d", i, r_lat, ref_steps(opc, cnt) + 1); end
            checks++; if (r_ssum !== cnt) begin errors++; $display("FAIL rand_bits_%0d got=%0d exp=%0d", i, r_ssum, cnt); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_rsp();
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_opc   = 2'b00;
        bus.req_cnt   = '0;
        bus.req_data  = '0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
